branch_ctrl: RTL and testbench
==============================

BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 id_valid  in  1  an instruction occupies the ID stage this cycle.
REQ-004 beq, bne, true, ComBranch  in  1 each  ID-stage branch class flags; true qualifies ComBranch.
REQ-005 Equal  in  1  ID-stage comparator result for the current rs/rt values.
REQ-006 id_rs, id_rt  in  5 each  ID-stage source register numbers.
REQ-007 ex_regwrite, ex_memread  in  1 each; ex_rd  in  5  EX-stage destination info.
REQ-008 mem_memread  in  1; mem_rd  in  5  MEM-stage load destination.
REQ-009 pc_src  out  1  select branch target for next PC.
REQ-010 stall  out  1  hold PC and IF/ID, insert bubble into ID/EX.
REQ-011 flush_ifid  out  1  squash the IF/ID register.
REQ-012 branch_cnt, taken_cnt  out  32 each  resolved-branch and taken-branch counters.
REQ-013 state_o  out  2  current FSM state, for debug.

Function
REQ-014 is_br = id_valid & (beq | bne | (true & ComBranch)); all other ID instructions never stall, flush or count.
REQ-015 taken = (beq & Equal) | (bne & ~Equal) | (true & ComBranch & ~Equal), evaluated only in the cycle of resolution.
REQ-016 dep(r) = (r != 0) & (r == id_rs | r == id_rt); register 0 never causes a hazard.
REQ-017 FSM states: IDLE=0, WAIT_LD2=1, WAIT_1=2, RESOLVE=3.
REQ-018 IDLE, is_br: ex_memread & dep(ex_rd) -> WAIT_LD2; else (ex_regwrite & dep(ex_rd)) or (mem_memread & dep(mem_rd)) -> WAIT_1; else resolve in this same cycle and stay in IDLE.
REQ-019 WAIT_LD2 -> WAIT_1 unconditionally; WAIT_1 -> RESOLVE unconditionally; RESOLVE -> IDLE unconditionally.
REQ-020 stall = 1 combinationally in IDLE when a hazard is detected, and in WAIT_LD2 and WAIT_1; stall = 0 in RESOLVE.
REQ-021 Resolution cycle (IDLE with no hazard, or RESOLVE): pc_src = flush_ifid = taken, combinationally in that cycle; branch_cnt += 1; taken_cnt += taken.
REQ-022 Branch latency: 0 stall cycles with no hazard, 2 after an ALU or MEM-load producer, 3 after an EX-load producer.
REQ-023 pc_src and flush_ifid are 0 in every non-resolution cycle; stall and flush_ifid are never both 1.
REQ-024 Counters wrap from 0xFFFFFFFF to 0 with no saturation; both may increment in the same cycle.
REQ-025 In RESOLVE, hazard inputs are ignored; the branch resolves with the Equal value present in that cycle.
REQ-026 Branch flags deasserting during WAIT_* do not abort the sequence; the FSM completes to IDLE, and RESOLVE resolves taken from the current inputs.

Reset
REQ-027 rst_n low asynchronously forces state=IDLE and branch_cnt=taken_cnt=0; pc_src, stall and flush_ifid read 0 while rst_n is low.
REQ-028 Reset asserted mid-stall abandons the branch with no count update; the first edge after release evaluates a fresh IDLE.

Structure
REQ-029 The FSM state encodings and the 5-bit register-number width belong in the shared CPU package, alongside the opcode constants.
REQ-030 Hazard detection (REQ-016/018) is one sub-module, branch_hazard_detect, purely combinational; the FSM and counters stay in branch_ctrl.

Verification
REQ-031 beq, Equal=1, no hazards -> pc_src=flush_ifid=1 the same cycle, stall=0; branch_cnt=1, taken_cnt=1.
REQ-032 bne, Equal=1, ex_regwrite=1, ex_rd=id_rs=5 -> stall=1 for 2 cycles, then RESOLVE with pc_src=0; branch_cnt=1, taken_cnt=0.
REQ-033 beq with ex_memread=1, ex_rd=id_rt=8 -> states 0,1,2,3,0; stall for 3 cycles; Equal=1 in RESOLVE -> flush_ifid=1.
REQ-034 beq with ex_rd=0, ex_regwrite=1 -> no stall; immediate resolution.
REQ-035 Preload branch_cnt=0xFFFFFFFF via 2^32 resolutions or a forced value, one more branch -> branch_cnt=0.
REQ-036 rst_n pulsed low while in WAIT_1 -> state=0 and stall=0 immediately; counters=0.

Source files
------------

// File: rtl/branch_ctrl_pkg.sv
// Shared CPU definitions: register-number width, opcode constants and the
// branch-control FSM encoding, plus the operand-dependency helper.
// Latency: n/a (types and constants only). Backpressure: n/a.
package branch_ctrl_pkg;

  localparam int REG_W = 5;
  typedef logic [REG_W-1:0] reg_num_t;

  // Primary opcode field values seen by the decoder.
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_LD2 = 2'd1,
    ST_WAIT_1   = 2'd2,
    ST_RESOLVE  = 2'd3
  } br_state_e;

  // A producer register is a dependency of the branch when it matches either
  // source; $zero is hard-wired and can never be a real producer.
  function automatic logic reg_dep(input reg_num_t r, input reg_num_t rs,
                                   input reg_num_t rt);
    return (r != '0) && ((r == rs) || (r == rt));
  endfunction

endpackage

// File: rtl/branch_ctrl_hazard_detect.sv
// Branch operand hazard detection: classifies the ID-stage instruction and
// flags EX/MEM producers the ID-stage comparator would otherwise read early.
// Latency: purely combinational. Backpressure: none; results feed the FSM.
// Ports: ID branch flags + rs/rt in, EX/MEM destination info in;
//        is_br, haz_ex_load (needs 3-cycle wait), haz_any out.
module branch_hazard_detect
  import branch_ctrl_pkg::*;
(
  input  logic     id_valid,
  input  logic     beq,
  input  logic     bne,
  input  logic     true,
  input  logic     ComBranch,
  input  reg_num_t id_rs,
  input  reg_num_t id_rt,
  input  logic     ex_regwrite,
  input  logic     ex_memread,
  input  reg_num_t ex_rd,
  input  logic     mem_memread,
  input  reg_num_t mem_rd,
  output logic     is_br,
  output logic     haz_ex_load,
  output logic     haz_any
);

  logic ex_dep;
  logic mem_dep;

  assign ex_dep  = reg_dep(ex_rd, id_rs, id_rt);
  assign mem_dep = reg_dep(mem_rd, id_rs, id_rt);

  assign is_br       = id_valid & (beq | bne | (true & ComBranch));
  assign haz_ex_load = ex_memread & ex_dep;
  assign haz_any     = haz_ex_load | (ex_regwrite & ex_dep) | (mem_memread & mem_dep);

endmodule

// File: rtl/branch_ctrl.sv
// ID-stage branch resolution controller: stalls until branch operands are
// forwardable, then redirects the PC and squashes IF/ID when taken.
// Latency: 0 stalls clean, 2 after ALU/MEM-load producer, 3 after EX load.
// Backpressure: stall holds PC and IF/ID and bubbles ID/EX while waiting.
// Ports: clk, rst_n; ID/EX/MEM hazard and branch inputs; pc_src, stall,
//        flush_ifid, branch_cnt, taken_cnt, state_o outputs.
module branch_ctrl
  import branch_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic        beq,
  input  logic        bne,
  input  logic        true,
  input  logic        ComBranch,
  input  logic        Equal,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        ex_regwrite,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rd,
  input  logic        mem_memread,
  input  logic [4:0]  mem_rd,
  output logic        pc_src,
  output logic        stall,
  output logic        flush_ifid,
  output logic [31:0] branch_cnt,
  output logic [31:0] taken_cnt,
  output logic [1:0]  state_o
);

  br_state_e   state_q, state_d;
  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] taken_cnt_q, taken_cnt_d;

  logic is_br;
  logic haz_ex_load;
  logic haz_any;
  logic taken;
  logic resolve;
  logic stall_raw;

  branch_hazard_detect u_hazard (
    .id_valid    (id_valid),
    .beq         (beq),
    .bne         (bne),
    .true        (true),
    .ComBranch   (ComBranch),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .ex_regwrite (ex_regwrite),
    .ex_memread  (ex_memread),
    .ex_rd       (ex_rd),
    .mem_memread (mem_memread),
    .mem_rd      (mem_rd),
    .is_br       (is_br),
    .haz_ex_load (haz_ex_load),
    .haz_any     (haz_any)
  );

  // In RESOLVE the branch flags are taken as presented that cycle, even if
  // the decoder dropped them during the wait.
  assign taken = (beq & Equal) | (bne & ~Equal) | (true & ComBranch & ~Equal);

  always_comb begin
    state_d      = state_q;
    branch_cnt_d = branch_cnt_q;
    taken_cnt_d  = taken_cnt_q;
    resolve      = 1'b0;
    stall_raw    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (is_br) begin
          if (haz_ex_load) begin
            state_d   = ST_WAIT_LD2;
            stall_raw = 1'b1;
          end else if (haz_any) begin
            state_d   = ST_WAIT_1;
            stall_raw = 1'b1;
          end else begin
            resolve = 1'b1;
          end
        end
      end
      ST_WAIT_LD2: begin
        state_d   = ST_WAIT_1;
        stall_raw = 1'b1;
      end
      ST_WAIT_1: begin
        state_d   = ST_RESOLVE;
        stall_raw = 1'b1;
      end
      ST_RESOLVE: begin
        state_d = ST_IDLE;
        resolve = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (resolve) begin
      branch_cnt_d = branch_cnt_q + 32'd1;
      taken_cnt_d  = taken_cnt_q + {31'd0, taken};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      branch_cnt_q <= '0;
      taken_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      branch_cnt_q <= branch_cnt_d;
      taken_cnt_q  <= taken_cnt_d;
    end
  end

  // Control outputs are decoded from live inputs, so qualify them with
  // rst_n to keep the pipeline quiet while reset is held.
  assign stall      = rst_n & stall_raw;
  assign pc_src     = rst_n & resolve & taken;
  assign flush_ifid = rst_n & resolve & taken;

  assign branch_cnt = branch_cnt_q;
  assign taken_cnt  = taken_cnt_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a countdown-based model.
// Latency/backpressure: n/a (testbench).
module tb_branch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        id_valid, beq, bne, tru, ComBranch, Equal;
  logic [4:0]  id_rs, id_rt, ex_rd, mem_rd;
  logic        ex_regwrite, ex_memread, mem_memread;
  logic        pc_src, stall, flush_ifid;
  logic [31:0] branch_cnt, taken_cnt;
  logic [1:0]  state_o;
  logic        preload;

  int total = 0;
  int bad   = 0;

  branch_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .beq         (beq),
    .bne         (bne),
    .true        (tru),
    .ComBranch   (ComBranch),
    .Equal       (Equal),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .ex_regwrite (ex_regwrite),
    .ex_memread  (ex_memread),
    .ex_rd       (ex_rd),
    .mem_memread (mem_memread),
    .mem_rd      (mem_rd),
    .pc_src      (pc_src),
    .stall       (stall),
    .flush_ifid  (flush_ifid),
    .branch_cnt  (branch_cnt),
    .taken_cnt   (taken_cnt),
    .state_o     (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clr();
    id_valid = 0; beq = 0; bne = 0; tru = 0; ComBranch = 0; Equal = 0;
    id_rs = 0; id_rt = 0; ex_rd = 0; mem_rd = 0;
    ex_regwrite = 0; ex_memread = 0; mem_memread = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  // 'left' counts cycles until the pending branch resolves (0 = nothing
  // pending). An EX-load producer makes the branch wait 3 more cycles,
  // an ALU/MEM-load producer 2 more; the last of those is the resolution.
  int          left = 0;
  logic [31:0] m_br = 0;
  logic [31:0] m_tk = 0;

  function automatic logic dep(input logic [4:0] r, input logic [4:0] rs, input logic [4:0] rt);
    return (r != 0) && (r == rs || r == rt);
  endfunction

  always @(negedge clk) begin
    logic isbr, tk, hz_ld, hz_1, res, e_stall;
    int   e_state;
    if (!rst_n) begin
      left = 0; m_br = 0; m_tk = 0;
      chk("rst_state", {30'd0, state_o}, 0);
      chk("rst_stall", {31'd0, stall}, 0);
      chk("rst_pc_src", {31'd0, pc_src}, 0);
      chk("rst_flush", {31'd0, flush_ifid}, 0);
      chk("rst_branch_cnt", branch_cnt, 0);
      chk("rst_taken_cnt", taken_cnt, 0);
    end else begin
      if (preload) m_br = 32'hFFFF_FFFF;
      isbr  = id_valid && (beq || bne || (tru && ComBranch));
      tk    = (beq && Equal) || (bne && !Equal) || (tru && ComBranch && !Equal);
      hz_ld = ex_memread && dep(ex_rd, id_rs, id_rt);
      hz_1  = (ex_regwrite && dep(ex_rd, id_rs, id_rt)) || (mem_memread && dep(mem_rd, id_rs, id_rt));
      e_state = (left == 0) ? 0 : 4 - left;
      res     = (left == 1) || (left == 0 && isbr && !hz_ld && !hz_1);
      e_stall = (left >= 2) || (left == 0 && isbr && (hz_ld || hz_1));
      chk("state_o", {30'd0, state_o}, e_state);
      chk("stall", {31'd0, stall}, {31'd0, e_stall});
      chk("pc_src", {31'd0, pc_src}, {31'd0, res && tk});
      chk("flush_ifid", {31'd0, flush_ifid}, {31'd0, res && tk});
      chk("branch_cnt", branch_cnt, m_br);
      chk("taken_cnt", taken_cnt, m_tk);
      if (left > 0) left--;
      else if (isbr && hz_ld) left = 3;
      else if (isbr && hz_1) left = 2;
      if (res) begin
        m_br = m_br + 1;
        m_tk = m_tk + (tk ? 1 : 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 0;
    preload = 0;
    clr();
    // Inputs that would stall if outputs were not held quiet in reset.
    id_valid = 1; beq = 1; ex_memread = 1; ex_rd = 1; id_rs = 1;
    repeat (2) next_cycle();
    sample();
    chk("reset_stall_lit", {31'd0, stall}, 0);
    chk("reset_state_lit", {30'd0, state_o}, 0);
    next_cycle();
    rst_n = 1;
    clr();

    // Clean beq taken: resolves in the same cycle.
    next_cycle();
    clr(); id_valid = 1; beq = 1; Equal = 1;
    sample();
    chk("t1_pc_src", {31'd0, pc_src}, 1);
    chk("t1_flush", {31'd0, flush_ifid}, 1);
    chk("t1_stall", {31'd0, stall}, 0);
    next_cycle(); clr();
    sample();
    chk("t1_branch_cnt", branch_cnt, 1);
    chk("t1_taken_cnt", taken_cnt, 1);

    // bne after ALU producer on rs: 2 stall cycles, then not taken.
    next_cycle();
    clr(); id_valid = 1; bne = 1; Equal = 1; ex_regwrite = 1; ex_rd = 5; id_rs = 5;
    sample();
    chk("t2_stall0", {31'd0, stall}, 1);
    next_cycle();
    sample();
    chk("t2_stall1", {31'd0, stall}, 1);
    chk("t2_state1", {30'd0, state_o}, 2);
    next_cycle();
    sample();
    chk("t2_res_stall", {31'd0, stall}, 0);
    chk("t2_res_state", {30'd0, state_o}, 3);
    chk("t2_res_pc_src", {31'd0, pc_src}, 0);
    next_cycle(); clr();
    sample();
    chk("t2_branch_cnt", branch_cnt, 2);
    chk("t2_taken_cnt", taken_cnt, 1);

    // beq after EX load on rt: states 0,1,2,3, Equal=1 only at resolve.
    next_cycle();
    clr(); id_valid = 1; beq = 1; ex_memread = 1; ex_rd = 8; id_rt = 8;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) next_cycle();
      if (i == 3) Equal = 1;
      sample();
      chk("t3_state", {30'd0, state_o}, i);
      chk("t3_stall", {31'd0, stall}, (i < 3) ? 1 : 0);
    end
    chk("t3_flush", {31'd0, flush_ifid}, 1);
    next_cycle(); clr();
    sample();
    chk("t3_state_end", {30'd0, state_o}, 0);
    chk("t3_branch_cnt", branch_cnt, 3);
    chk("t3_taken_cnt", taken_cnt, 2);

    // Producer writes $zero: no hazard, immediate not-taken resolution.
    next_cycle();
    clr(); id_valid = 1; beq = 1; ex_regwrite = 1; mem_memread = 1;
    sample();
    chk("t4_stall", {31'd0, stall}, 0);
    chk("t4_pc_src", {31'd0, pc_src}, 0);
    next_cycle(); clr();
    sample();
    chk("t4_branch_cnt", branch_cnt, 4);

    // Counter wrap.
    next_cycle();
    clr();
    force dut.branch_cnt_q = 32'hFFFF_FFFF;
    preload = 1;
    #1 release dut.branch_cnt_q;
    next_cycle();
    preload = 0;
    id_valid = 1; beq = 1;
    sample();
    chk("t5_pre_wrap", branch_cnt, 32'hFFFF_FFFF);
    next_cycle(); clr();
    sample();
    chk("t5_wrapped", branch_cnt, 0);
    chk("t5_taken_cnt", taken_cnt, 2);

    // Reset while in WAIT_1.
    next_cycle();
    clr(); id_valid = 1; bne = 1; ex_regwrite = 1; ex_rd = 3; id_rt = 3;
    next_cycle();
    #1 rst_n = 0;
    #1;
    chk("t6_state", {30'd0, state_o}, 0);
    chk("t6_stall", {31'd0, stall}, 0);
    chk("t6_branch_cnt", branch_cnt, 0);
    chk("t6_taken_cnt", taken_cnt, 0);
    next_cycle();
    rst_n = 1;
    clr();

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      next_cycle();
      rst_n       = ($urandom_range(0, 799) != 0);
      id_valid    = ($urandom_range(0, 3) != 0);
      beq         = ($urandom_range(0, 2) == 0);
      bne         = ($urandom_range(0, 2) == 0);
      tru         = $urandom_range(0, 1);
      ComBranch   = $urandom_range(0, 1);
      Equal       = $urandom_range(0, 1);
      id_rs       = 5'($urandom_range(0, 3));
      id_rt       = 5'($urandom_range(0, 3));
      ex_rd       = 5'($urandom_range(0, 3));
      mem_rd      = 5'($urandom_range(0, 3));
      ex_regwrite = $urandom_range(0, 1);
      ex_memread  = ($urandom_range(0, 3) == 0);
      mem_memread = ($urandom_range(0, 3) == 0);
    end
    next_cycle();
    rst_n = 1;
    clr();
    repeat (5) next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
